branch_resolve: RTL and testbench
=================================

BRANCH_RESOLVE -- requirements
Module: branch_resolve

Interface
REQ-001 Parameter FLUSH_CYCLES, default 2 (legal range 1-15): number of cycles flush_w_o_h is held after a taken redirect.
REQ-002 The block SHALL use one clock and an asynchronous active-low reset, with the following ports.
- clk_w_i  in  1  rising-edge clock.
- rst_w_i_l  in  1  asynchronous reset, active-low.
- valid_w_i_h  in  1  request valid.
- ready_w_o_h  out  1  request accepted when high together with valid_w_i_h.
- funct3_w_i  in  3  RV32 branch funct3.
- is_branch_w_i_h / is_jal_w_i_h / is_jalr_w_i_h  in  1 each  op class.
- pc_w_i  in  32  instruction PC.
- imm_w_i  in  32  sign-extended immediate.
- rs1_data_w_i  in  32  rs1 value, used by JALR only.
- eq_w_i_h, gteu_w_i_h, ltu_w_i_h, gtes_w_i_h, lts_w_i_h  in  1 each  comparator flags.
- res_valid_w_o_h  out  1  result valid.
- res_ready_w_i_h  in  1  result consumed.
- taken_w_o_h  out  1  redirect required.
- target_w_o  out  32  redirect target.
- link_w_o  out  32  pc+4 for JAL/JALR.
- misalign_w_o_h  out  1  taken target not 4-byte aligned.
- illegal_w_o_h  out  1  bad funct3 or bad op-class encoding.
- flush_w_o_h  out  1  pipeline flush.
- taken_cnt_w_o  out  16  count of taken redirects.

Function
REQ-003 The FSM SHALL have the states IDLE, RESULT and FLUSH.
REQ-004 ready_w_o_h SHALL be 1 only in IDLE with reset deasserted; it is a combinational function of state only.
REQ-005 In IDLE, a request with valid_w_i_h=1 SHALL be captured at the clock edge and the FSM SHALL move to RESULT; the latency is 1 cycle to res_valid_w_o_h.
REQ-006 In RESULT, res_valid_w_o_h=1 and all result outputs SHALL stay stable until the cycle in which res_ready_w_i_h=1.
REQ-007 Branch condition by funct3:
- 000 eq
- 001 !eq
- 100 lts
- 101 gtes
- 110 ltu
- 111 gteu
- 010/011: illegal_w_o_h=1, not taken.
REQ-008 JAL and JALR SHALL always be taken; link_w_o=pc+4 (mod 2^32), otherwise 0.
REQ-009 Target calculation:
- Branch/JAL: target_w_o=pc+imm (mod 2^32).
- JALR: target_w_o=(rs1+imm) & 0xFFFFFFFE.
- Not taken: target_w_o=pc+4.
REQ-010 If zero or more than one of the op-class inputs is set, illegal_w_o_h=1, taken_w_o_h=0 and no flush SHALL occur.
REQ-011 A taken result with target[1]=1 SHALL set misalign_w_o_h=1 and force taken_w_o_h=0, with no flush and no count increment.
REQ-012 On the RESULT handshake:
- taken=1: go to FLUSH and increment taken_cnt_w_o.
- otherwise: go to IDLE.
REQ-013 In FLUSH, flush_w_o_h=1 for exactly FLUSH_CYCLES consecutive cycles, res_valid_w_o_h=0 and ready_w_o_h=0; the FSM then returns to IDLE.
REQ-014 taken_cnt_w_o SHALL wrap from 0xFFFF to 0x0000.
REQ-015 The comparator flags SHALL be sampled only in the capture cycle; flag changes afterwards SHALL NOT affect a held result.
REQ-016 Back-to-back operation: a new request MAY be accepted in the first IDLE cycle after a not-taken handshake, giving a minimum spacing of 2 cycles.

Reset
REQ-017 Asserting rst_w_i_l low SHALL immediately force state IDLE and set every output and register to 0, including taken_cnt_w_o, flush_w_o_h and ready_w_o_h.
REQ-018 Reset during FLUSH or RESULT SHALL abort the operation immediately; no partial flush or held result SHALL remain after release.
REQ-019 ready_w_o_h SHALL rise in the first cycle after reset release.

Verification
REQ-020 BEQ test: funct3=000, eq=1, pc=0x100, imm=0x20, res_ready tied 1 -> next cycle taken=1 and target=0x120; flush high for 2 cycles; taken_cnt=1; ready low for 3 cycles total.
REQ-021 BLT not-taken test: funct3=100, lts=0, pc=0x200 -> taken=0, target=0x204, no flush, new request accepted 2 cycles after the first.
REQ-022 JALR test: rs1=0x1003, imm=0x4, pc=0x40 -> target=0x1006 and misalign=1, taken=0, link=0x44, no flush.
REQ-023 Illegal-encoding test: funct3=010, and separately is_jal and is_branch both set -> illegal=1, taken=0, counter unchanged.
REQ-024 Backpressure and counter-wrap test: hold res_ready=0 for 5 cycles while toggling the flags -> result outputs stable. Preload 0xFFFF taken redirects and issue one more -> taken_cnt=0x0000.
REQ-025 Reset mid-flush test: assert reset in flush cycle 1 -> flush=0 and taken_cnt=0 immediately; ready=1 in the first cycle after release.

Source files
------------

// File: rtl/branch_resolve_if.sv
// Request/result bundle between the decode stage and the branch resolver.
// The master side issues resolve requests and consumes results; the slave
// side is the resolver itself.
interface branch_resolve_if;
  // request channel
  logic        valid_w_i_h;
  logic        ready_w_o_h;
  logic [2:0]  funct3_w_i;
  logic        is_branch_w_i_h;
  logic        is_jal_w_i_h;
  logic        is_jalr_w_i_h;
  logic [31:0] pc_w_i;
  logic [31:0] imm_w_i;
  logic [31:0] rs1_data_w_i;
  logic        eq_w_i_h;
  logic        gteu_w_i_h;
  logic        ltu_w_i_h;
  logic        gtes_w_i_h;
  logic        lts_w_i_h;
  // result channel
  logic        res_valid_w_o_h;
  logic        res_ready_w_i_h;
  logic        taken_w_o_h;
  logic [31:0] target_w_o;
  logic [31:0] link_w_o;
  logic        misalign_w_o_h;
  logic        illegal_w_o_h;
  logic        flush_w_o_h;
  logic [15:0] taken_cnt_w_o;

  modport master (
    output valid_w_i_h, funct3_w_i, is_branch_w_i_h, is_jal_w_i_h, is_jalr_w_i_h,
    output pc_w_i, imm_w_i, rs1_data_w_i,
    output eq_w_i_h, gteu_w_i_h, ltu_w_i_h, gtes_w_i_h, lts_w_i_h,
    output res_ready_w_i_h,
    input  ready_w_o_h, res_valid_w_o_h, taken_w_o_h, target_w_o, link_w_o,
    input  misalign_w_o_h, illegal_w_o_h, flush_w_o_h, taken_cnt_w_o
  );

  modport slave (
    input  valid_w_i_h, funct3_w_i, is_branch_w_i_h, is_jal_w_i_h, is_jalr_w_i_h,
    input  pc_w_i, imm_w_i, rs1_data_w_i,
    input  eq_w_i_h, gteu_w_i_h, ltu_w_i_h, gtes_w_i_h, lts_w_i_h,
    input  res_ready_w_i_h,
    output ready_w_o_h, res_valid_w_o_h, taken_w_o_h, target_w_o, link_w_o,
    output misalign_w_o_h, illegal_w_o_h, flush_w_o_h, taken_cnt_w_o
  );
endinterface

// File: rtl/branch_resolve.sv
// RV32 branch/jump resolver. A request is captured in IDLE, its outcome is
// held in RESULT until the consumer takes it, and a taken redirect then
// holds the pipeline flush for FLUSH_CYCLES cycles before the next request.
module branch_resolve #(
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input logic             clk_w_i,
  input logic             rst_w_i_l,
  branch_resolve_if.slave bus
);

  localparam logic [3:0] FLUSH_LAST = 4'(FLUSH_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RESULT = 2'd1,
    FLUSH  = 2'd2
  } state_t;

  // Branch condition for a funct3 code; codes 010/011 never take.
  function automatic logic branch_cond(
    input logic [2:0] f3,
    input logic       eq,
    input logic       gteu,
    input logic       ltu,
    input logic       gtes,
    input logic       lts
  );
    logic c;
    case (f3)
      3'b000:  c = eq;
      3'b001:  c = ~eq;
      3'b100:  c = lts;
      3'b101:  c = gtes;
      3'b110:  c = ltu;
      3'b111:  c = gteu;
      default: c = 1'b0;
    endcase
    return c;
  endfunction

  state_t      state_r;
  state_t      state_nxt_s;
  logic [3:0]  flush_cnt_r;
  logic [3:0]  flush_cnt_nxt_s;
  logic        flush_r;
  logic        res_valid_r;
  logic        capture_s;
  logic        clear_res_s;
  logic        cnt_inc_s;

  logic        taken_r;
  logic [31:0] target_r;
  logic [31:0] link_r;
  logic        misalign_r;
  logic        illegal_r;
  logic [15:0] taken_cnt_r;

  logic [1:0]  cls_cnt_s;
  logic        one_class_s;
  logic        f3_bad_s;
  logic        want_s;
  logic [31:0] pc_plus4_s;
  logic [31:0] dest_s;
  logic        taken_s;
  logic        misalign_s;
  logic        illegal_s;
  logic [31:0] link_s;

  // Resolve the incoming request: class check, condition, target and link.
  always_comb begin
    cls_cnt_s   = {1'b0, bus.is_branch_w_i_h} + {1'b0, bus.is_jal_w_i_h}
                + {1'b0, bus.is_jalr_w_i_h};
    one_class_s = (cls_cnt_s == 2'd1);
    f3_bad_s    = bus.is_branch_w_i_h & (bus.funct3_w_i[2:1] == 2'b01);
    pc_plus4_s  = bus.pc_w_i + 32'd4;
    want_s      = 1'b0;
    dest_s      = pc_plus4_s;
    link_s      = 32'd0;

    if (!one_class_s) begin
      want_s = 1'b0;
    end else if (bus.is_jal_w_i_h || bus.is_jalr_w_i_h) begin
      want_s = 1'b1;
      link_s = pc_plus4_s;
    end else begin
      want_s = branch_cond(bus.funct3_w_i, bus.eq_w_i_h, bus.gteu_w_i_h,
                           bus.ltu_w_i_h, bus.gtes_w_i_h, bus.lts_w_i_h);
    end

    if (!want_s) begin
      dest_s = pc_plus4_s;
    end else if (bus.is_jalr_w_i_h) begin
      dest_s = (bus.rs1_data_w_i + bus.imm_w_i) & 32'hFFFF_FFFE;
    end else begin
      dest_s = bus.pc_w_i + bus.imm_w_i;
    end

    // A redirect to a non-word-aligned target is reported, not followed.
    misalign_s = want_s & dest_s[1];
    taken_s    = want_s & ~dest_s[1];
    illegal_s  = ~one_class_s | f3_bad_s;
  end

  // Next-state and handshake decode for the IDLE/RESULT/FLUSH sequence.
  always_comb begin
    state_nxt_s     = state_r;
    flush_cnt_nxt_s = flush_cnt_r;
    capture_s       = 1'b0;
    clear_res_s     = 1'b0;
    cnt_inc_s       = 1'b0;
    case (state_r)
      IDLE: begin
        if (bus.valid_w_i_h) begin
          capture_s   = 1'b1;
          state_nxt_s = RESULT;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      RESULT: begin
        if (bus.res_ready_w_i_h) begin
          clear_res_s = 1'b1;
          if (taken_r) begin
            cnt_inc_s       = 1'b1;
            flush_cnt_nxt_s = FLUSH_LAST;
            state_nxt_s     = FLUSH;
          end else begin
            state_nxt_s = IDLE;
          end
        end else begin
          state_nxt_s = RESULT;
        end
      end
      FLUSH: begin
        if (flush_cnt_r == 4'd0) begin
          state_nxt_s = IDLE;
        end else begin
          flush_cnt_nxt_s = flush_cnt_r - 4'd1;
          state_nxt_s     = FLUSH;
        end
      end
      default: begin
        state_nxt_s     = IDLE;
        flush_cnt_nxt_s = 4'd0;
      end
    endcase
  end

  // State register with registered flush and result-valid strobes.
  always_ff @(posedge clk_w_i or negedge rst_w_i_l) begin
    if (!rst_w_i_l) begin
      state_r     <= IDLE;
      flush_cnt_r <= 4'd0;
      flush_r     <= 1'b0;
      res_valid_r <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      flush_cnt_r <= flush_cnt_nxt_s;
      flush_r     <= (state_nxt_s == FLUSH);
      res_valid_r <= (state_nxt_s == RESULT);
    end
  end

  // Result hold registers: loaded on capture, cleared once consumed, so
  // later changes on the request/flag inputs cannot disturb a held result.
  always_ff @(posedge clk_w_i or negedge rst_w_i_l) begin
    if (!rst_w_i_l) begin
      taken_r    <= 1'b0;
      target_r   <= 32'd0;
      link_r     <= 32'd0;
      misalign_r <= 1'b0;
      illegal_r  <= 1'b0;
    end else if (capture_s) begin
      taken_r    <= taken_s;
      target_r   <= dest_s;
      link_r     <= link_s;
      misalign_r <= misalign_s;
      illegal_r  <= illegal_s;
    end else if (clear_res_s) begin
      taken_r    <= 1'b0;
      target_r   <= 32'd0;
      link_r     <= 32'd0;
      misalign_r <= 1'b0;
      illegal_r  <= 1'b0;
    end else begin
      taken_r    <= taken_r;
      target_r   <= target_r;
      link_r     <= link_r;
      misalign_r <= misalign_r;
      illegal_r  <= illegal_r;
    end
  end

  // Taken-redirect counter, wraps naturally at 16 bits.
  always_ff @(posedge clk_w_i or negedge rst_w_i_l) begin
    if (!rst_w_i_l) begin
      taken_cnt_r <= 16'd0;
    end else if (cnt_inc_s) begin
      taken_cnt_r <= taken_cnt_r + 16'd1;
    end else begin
      taken_cnt_r <= taken_cnt_r;
    end
  end

  assign bus.ready_w_o_h     = (state_r == IDLE) & rst_w_i_l;
  assign bus.res_valid_w_o_h = res_valid_r;
  assign bus.flush_w_o_h     = flush_r;
  assign bus.taken_w_o_h     = taken_r;
  assign bus.target_w_o      = target_r;
  assign bus.link_w_o        = link_r;
  assign bus.misalign_w_o_h  = misalign_r;
  assign bus.illegal_w_o_h   = illegal_r;
  assign bus.taken_cnt_w_o   = taken_cnt_r;

endmodule

// File: tb/tb_branch_resolve.sv
// Self-checking bench for branch_resolve: directed scenarios plus a
// randomized run against a behavioural model of the resolve rules.
module tb_branch_resolve;

  localparam int FLUSH_N = 2;

  typedef struct packed {
    logic        taken;
    logic [31:0] target;
    logic [31:0] link;
    logic        mis;
    logic        ill;
  } res_t;

  logic clk;
  logic rst_n;
  int   n_vec;
  int   n_err;
  res_t exp_res;
  logic [15:0] exp_cnt;

  branch_resolve_if bi ();

  branch_resolve #(.FLUSH_CYCLES(FLUSH_N)) dut (
    .clk_w_i   (clk),
    .rst_w_i_l (rst_n),
    .bus       (bi)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference: what the resolver must report for one request.
  function automatic res_t model(input logic [2:0] f3, input logic br, input logic jal,
                                 input logic jalr, input logic [31:0] pc, input logic [31:0] imm,
                                 input logic [31:0] rs1, input logic [4:0] fl);
    res_t r;
    int   classes;
    bit   go;
    bit   bad;
    logic [31:0] dest;
    classes = int'(br) + int'(jal) + int'(jalr);
    bad = (classes != 1);
    go = 1'b0;
    if (!bad && (jal || jalr)) go = 1'b1;
    if (!bad && br) begin
      // fl = {eq, gteu, ltu, gtes, lts}
      if (f3 == 3'd0) go = fl[4];
      else if (f3 == 3'd1) go = !fl[4];
      else if (f3 == 3'd4) go = fl[0];
      else if (f3 == 3'd5) go = fl[1];
      else if (f3 == 3'd6) go = fl[2];
      else if (f3 == 3'd7) go = fl[3];
      else bad = 1'b1;
    end
    if (!go) dest = pc + 32'd4;
    else if (jalr) dest = {rs1 + imm} & 32'hFFFF_FFFE;
    else dest = pc + imm;
    r.target = dest;
    r.mis    = go && dest[1];
    r.taken  = go && !dest[1];
    r.link   = (!bad && (jal || jalr)) ? pc + 32'd4 : 32'd0;
    r.ill    = bad;
    return r;
  endfunction

  task automatic set_req(input logic [2:0] f3, input logic br, input logic jal, input logic jalr,
                         input logic [31:0] pc, input logic [31:0] imm, input logic [31:0] rs1,
                         input logic [4:0] fl);
    bi.funct3_w_i = f3;       bi.is_branch_w_i_h = br;
    bi.is_jal_w_i_h = jal;    bi.is_jalr_w_i_h = jalr;
    bi.pc_w_i = pc;           bi.imm_w_i = imm;       bi.rs1_data_w_i = rs1;
    {bi.eq_w_i_h, bi.gteu_w_i_h, bi.ltu_w_i_h, bi.gtes_w_i_h, bi.lts_w_i_h} = fl;
    bi.valid_w_i_h = 1'b1;
    exp_res = model(f3, br, jal, jalr, pc, imm, rs1, fl);
  endtask

  task automatic scramble_inputs();
    bi.funct3_w_i = 3'($urandom);
    bi.pc_w_i = $urandom;  bi.imm_w_i = $urandom;  bi.rs1_data_w_i = $urandom;
    {bi.eq_w_i_h, bi.gteu_w_i_h, bi.ltu_w_i_h, bi.gtes_w_i_h, bi.lts_w_i_h} = 5'($urandom);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    n_vec++;
    if (bi.ready_w_o_h !== 1'b0 || bi.res_valid_w_o_h !== 1'b0 || bi.flush_w_o_h !== 1'b0) begin
      n_err++;
      $display("FAIL reset_ctrl: ready=%b res_valid=%b flush=%b, required 0 0 0",
               bi.ready_w_o_h, bi.res_valid_w_o_h, bi.flush_w_o_h);
    end
    n_vec++;
    if (bi.taken_cnt_w_o !== 16'd0 || bi.taken_w_o_h !== 1'b0 || bi.target_w_o !== 32'd0) begin
      n_err++;
      $display("FAIL reset_data: cnt=%h taken=%b target=%h, required 0", bi.taken_cnt_w_o,
               bi.taken_w_o_h, bi.target_w_o);
    end
    rst_n = 1'b1;
    #1;
    n_vec++;
    if (bi.ready_w_o_h !== 1'b1) begin
      n_err++;
      $display("FAIL reset_release_ready: got %b, required 1", bi.ready_w_o_h);
    end
    exp_cnt = 16'd0;
  endtask

  task automatic test_beq();
    @(negedge clk);
    bi.res_ready_w_i_h = 1'b1;
    set_req(3'b000, 1'b1, 1'b0, 1'b0, 32'h100, 32'h20, 32'h0, 5'b10000);
    @(posedge clk);
    @(negedge clk);
    bi.valid_w_i_h = 1'b0;
    n_vec++;
    if (bi.res_valid_w_o_h !== 1'b1 || bi.taken_w_o_h !== 1'b1 || bi.target_w_o !== 32'h120
        || bi.ready_w_o_h !== 1'b0) begin
      n_err++;
      $display("FAIL beq_result: valid=%b taken=%b target=%h ready=%b, required 1 1 00000120 0",
               bi.res_valid_w_o_h, bi.taken_w_o_h, bi.target_w_o, bi.ready_w_o_h);
    end
    exp_cnt = exp_cnt + 16'd1;
    for (int k = 0; k <= FLUSH_N; k++) begin
      @(negedge clk);
      n_vec++;
      if (bi.flush_w_o_h !== (k < FLUSH_N) || bi.ready_w_o_h !== (k == FLUSH_N)
          || bi.taken_cnt_w_o !== exp_cnt) begin
        n_err++;
        $display("FAIL beq_flush[%0d]: flush=%b ready=%b cnt=%h, required %b %b %h", k,
                 bi.flush_w_o_h, bi.ready_w_o_h, bi.taken_cnt_w_o, k < FLUSH_N, k == FLUSH_N,
                 exp_cnt);
      end
    end
    bi.res_ready_w_i_h = 1'b0;
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    bi.res_ready_w_i_h = 1'b1;
    set_req(3'b100, 1'b1, 1'b0, 1'b0, 32'h200, 32'h40, 32'h0, 5'b00000);
    @(posedge clk);
    @(negedge clk);
    bi.valid_w_i_h = 1'b0;
    n_vec++;
    if (bi.taken_w_o_h !== 1'b0 || bi.target_w_o !== 32'h204 || bi.res_valid_w_o_h !== 1'b1) begin
      n_err++;
      $display("FAIL blt_result: taken=%b target=%h valid=%b, required 0 00000204 1",
               bi.taken_w_o_h, bi.target_w_o, bi.res_valid_w_o_h);
    end
    @(negedge clk);
    n_vec++;
    if (bi.ready_w_o_h !== 1'b1 || bi.flush_w_o_h !== 1'b0) begin
      n_err++;
      $display("FAIL blt_idle: ready=%b flush=%b, required 1 0", bi.ready_w_o_h, bi.flush_w_o_h);
    end
    // second request two cycles after the first: BNE with eq=1, not taken
    set_req(3'b001, 1'b1, 1'b0, 1'b0, 32'h300, 32'h80, 32'h0, 5'b10000);
    @(posedge clk);
    @(negedge clk);
    bi.valid_w_i_h = 1'b0;
    n_vec++;
    if (bi.res_valid_w_o_h !== 1'b1 || bi.taken_w_o_h !== 1'b0 || bi.target_w_o !== 32'h304) begin
      n_err++;
      $display("FAIL b2b_second: valid=%b taken=%b target=%h, required 1 0 00000304",
               bi.res_valid_w_o_h, bi.taken_w_o_h, bi.target_w_o);
    end
    @(negedge clk);
    bi.res_ready_w_i_h = 1'b0;
  endtask

  task automatic test_jalr_misalign();
    @(negedge clk);
    bi.res_ready_w_i_h = 1'b1;
    set_req(3'b000, 1'b0, 1'b0, 1'b1, 32'h40, 32'h4, 32'h1003, 5'b00000);
    @(posedge clk);
    @(negedge clk);
    bi.valid_w_i_h = 1'b0;
    n_vec++;
    if (bi.target_w_o !== 32'h1006 || bi.misalign_w_o_h !== 1'b1 || bi.taken_w_o_h !== 1'b0
        || bi.link_w_o !== 32'h44) begin
      n_err++;
      $display("FAIL jalr_result: target=%h mis=%b taken=%b link=%h, required 00001006 1 0 00000044",
               bi.target_w_o, bi.misalign_w_o_h, bi.taken_w_o_h, bi.link_w_o);
    end
    @(negedge clk);
    n_vec++;
    if (bi.flush_w_o_h !== 1'b0 || bi.ready_w_o_h !== 1'b1 || bi.taken_cnt_w_o !== exp_cnt) begin
      n_err++;
      $display("FAIL jalr_after: flush=%b ready=%b cnt=%h, required 0 1 %h", bi.flush_w_o_h,
               bi.ready_w_o_h, bi.taken_cnt_w_o, exp_cnt);
    end
    bi.res_ready_w_i_h = 1'b0;
  endtask

  task automatic test_illegal();
    for (int t = 0; t < 2; t++) begin
      @(negedge clk);
      bi.res_ready_w_i_h = 1'b1;
      if (t == 0) set_req(3'b010, 1'b1, 1'b0, 1'b0, 32'h500, 32'h10, 32'h0, 5'b11111);
      else        set_req(3'b000, 1'b1, 1'b1, 1'b0, 32'h600, 32'h10, 32'h0, 5'b11111);
      @(posedge clk);
      @(negedge clk);
      bi.valid_w_i_h = 1'b0;
      n_vec++;
      if (bi.illegal_w_o_h !== 1'b1 || bi.taken_w_o_h !== 1'b0 || bi.target_w_o !== exp_res.target) begin
        n_err++;
        $display("FAIL illegal[%0d]: ill=%b taken=%b target=%h, required 1 0 %h", t,
                 bi.illegal_w_o_h, bi.taken_w_o_h, bi.target_w_o, exp_res.target);
      end
      @(negedge clk);
      n_vec++;
      if (bi.flush_w_o_h !== 1'b0 || bi.taken_cnt_w_o !== exp_cnt) begin
        n_err++;
        $display("FAIL illegal_after[%0d]: flush=%b cnt=%h, required 0 %h", t, bi.flush_w_o_h,
                 bi.taken_cnt_w_o, exp_cnt);
      end
      bi.res_ready_w_i_h = 1'b0;
    end
  endtask

  task automatic test_random(input int n);
    int hold;
    int sel;
    logic br, jal, jalr;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      sel = $urandom_range(0, 9);
      br = (sel <= 5) || (sel == 8);
      jal = (sel == 6) || (sel == 8 && $urandom_range(0, 1) == 1);
      jalr = (sel == 7) || (sel == 8 && !jal);
      n_vec++;
      if (bi.ready_w_o_h !== 1'b1) begin
        n_err++;
        $display("FAIL rnd_ready[%0d]: got %b, required 1", i, bi.ready_w_o_h);
      end
      set_req(3'($urandom), br, jal, jalr, $urandom & 32'hFFFF_FFFC,
              $urandom & ((sel == 7) ? 32'hFFFF_FFFF : 32'h0000_FFFE),
              $urandom, 5'($urandom));
      @(posedge clk);
      hold = $urandom_range(0, 4);
      for (int h = 0; h <= hold; h++) begin
        @(negedge clk);
        bi.valid_w_i_h = 1'b0;
        scramble_inputs();
        n_vec++;
        if (bi.res_valid_w_o_h !== 1'b1 || bi.taken_w_o_h !== exp_res.taken
            || bi.target_w_o !== exp_res.target || bi.link_w_o !== exp_res.link
            || bi.misalign_w_o_h !== exp_res.mis || bi.illegal_w_o_h !== exp_res.ill) begin
          n_err++;
          $display("FAIL rnd_result[%0d.%0d]: v=%b t=%b tgt=%h lnk=%h m=%b i=%b, required 1 %b %h %h %b %b",
                   i, h, bi.res_valid_w_o_h, bi.taken_w_o_h, bi.target_w_o, bi.link_w_o,
                   bi.misalign_w_o_h, bi.illegal_w_o_h, exp_res.taken, exp_res.target,
                   exp_res.link, exp_res.mis, exp_res.ill);
        end
        bi.res_ready_w_i_h = (h == hold);
      end
      @(posedge clk);
      if (exp_res.taken) exp_cnt = exp_cnt + 16'd1;
      for (int k = 0; k <= (exp_res.taken ? FLUSH_N : 0); k++) begin
        @(negedge clk);
        bi.res_ready_w_i_h = 1'b0;
        n_vec++;
        if (bi.flush_w_o_h !== (exp_res.taken && k < FLUSH_N)
            || bi.ready_w_o_h !== (!exp_res.taken || k == FLUSH_N)
            || bi.res_valid_w_o_h !== 1'b0 || bi.taken_cnt_w_o !== exp_cnt) begin
          n_err++;
          $display("FAIL rnd_post[%0d.%0d]: flush=%b ready=%b v=%b cnt=%h, required cnt %h", i, k,
                   bi.flush_w_o_h, bi.ready_w_o_h, bi.res_valid_w_o_h, bi.taken_cnt_w_o, exp_cnt);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    @(negedge clk);
    bi.res_ready_w_i_h = 1'b0;
    set_req(3'b000, 1'b1, 1'b0, 1'b0, 32'h800, 32'h100, 32'h0, 5'b10000);
    @(posedge clk);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      bi.valid_w_i_h = 1'b0;
      {bi.eq_w_i_h, bi.gteu_w_i_h, bi.ltu_w_i_h, bi.gtes_w_i_h, bi.lts_w_i_h} = 5'($urandom);
      bi.eq_w_i_h = c[0];
      n_vec++;
      if (bi.res_valid_w_o_h !== 1'b1 || bi.taken_w_o_h !== 1'b1 || bi.target_w_o !== 32'h900
          || bi.flush_w_o_h !== 1'b0) begin
        n_err++;
        $display("FAIL bp_hold[%0d]: v=%b taken=%b target=%h flush=%b, required 1 1 00000900 0", c,
                 bi.res_valid_w_o_h, bi.taken_w_o_h, bi.target_w_o, bi.flush_w_o_h);
      end
    end
    bi.res_ready_w_i_h = 1'b1;
    @(negedge clk);
    bi.res_ready_w_i_h = 1'b0;
    exp_cnt = exp_cnt + 16'd1;
    n_vec++;
    if (bi.flush_w_o_h !== 1'b1 || bi.taken_cnt_w_o !== exp_cnt) begin
      n_err++;
      $display("FAIL bp_flush: flush=%b cnt=%h, required 1 %h", bi.flush_w_o_h,
               bi.taken_cnt_w_o, exp_cnt);
    end
    repeat (FLUSH_N) @(negedge clk);
  endtask

  task automatic test_wrap();
    @(negedge clk);
    force dut.taken_cnt_r = 16'hFFFF;
    #1;
    release dut.taken_cnt_r;
    exp_cnt = 16'hFFFF;
    @(negedge clk);
    bi.res_ready_w_i_h = 1'b1;
    set_req(3'b000, 1'b0, 1'b1, 1'b0, 32'h1000, 32'h40, 32'h0, 5'b00000);
    @(posedge clk);
    @(negedge clk);
    bi.valid_w_i_h = 1'b0;
    @(negedge clk);
    bi.res_ready_w_i_h = 1'b0;
    exp_cnt = exp_cnt + 16'd1;
    n_vec++;
    if (bi.taken_cnt_w_o !== exp_cnt || bi.flush_w_o_h !== 1'b1) begin
      n_err++;
      $display("FAIL cnt_wrap: cnt=%h flush=%b, required %h 1", bi.taken_cnt_w_o,
               bi.flush_w_o_h, exp_cnt);
    end
    repeat (FLUSH_N) @(negedge clk);
  endtask

  task automatic test_reset_mid_flush();
    @(negedge clk);
    bi.res_ready_w_i_h = 1'b1;
    set_req(3'b000, 1'b0, 1'b1, 1'b0, 32'h2000, 32'h8, 32'h0, 5'b00000);
    @(posedge clk);
    @(negedge clk);
    bi.valid_w_i_h = 1'b0;
    @(negedge clk);
    bi.res_ready_w_i_h = 1'b0;
    n_vec++;
    if (bi.flush_w_o_h !== 1'b1) begin
      n_err++;
      $display("FAIL rst_pre_flush: flush=%b, required 1", bi.flush_w_o_h);
    end
    rst_n = 1'b0;
    #1;
    exp_cnt = 16'd0;
    n_vec++;
    if (bi.flush_w_o_h !== 1'b0 || bi.taken_cnt_w_o !== exp_cnt || bi.ready_w_o_h !== 1'b0
        || bi.res_valid_w_o_h !== 1'b0) begin
      n_err++;
      $display("FAIL rst_mid_flush: flush=%b cnt=%h ready=%b v=%b, required 0 0000 0 0",
               bi.flush_w_o_h, bi.taken_cnt_w_o, bi.ready_w_o_h, bi.res_valid_w_o_h);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_vec++;
    if (bi.ready_w_o_h !== 1'b1) begin
      n_err++;
      $display("FAIL rst_release_ready: got %b, required 1", bi.ready_w_o_h);
    end
    @(negedge clk);
    n_vec++;
    if (bi.flush_w_o_h !== 1'b0 || bi.res_valid_w_o_h !== 1'b0 || bi.ready_w_o_h !== 1'b1) begin
      n_err++;
      $display("FAIL rst_after: flush=%b v=%b ready=%b, required 0 0 1", bi.flush_w_o_h,
               bi.res_valid_w_o_h, bi.ready_w_o_h);
    end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    exp_cnt = 16'd0;
    exp_res = '0;
    rst_n = 1'b0;
    bi.valid_w_i_h = 1'b0;     bi.res_ready_w_i_h = 1'b0;
    bi.funct3_w_i = 3'd0;      bi.is_branch_w_i_h = 1'b0;
    bi.is_jal_w_i_h = 1'b0;    bi.is_jalr_w_i_h = 1'b0;
    bi.pc_w_i = 32'd0;         bi.imm_w_i = 32'd0;      bi.rs1_data_w_i = 32'd0;
    bi.eq_w_i_h = 1'b0;        bi.gteu_w_i_h = 1'b0;    bi.ltu_w_i_h = 1'b0;
    bi.gtes_w_i_h = 1'b0;      bi.lts_w_i_h = 1'b0;

    test_reset();
    test_beq();
    test_back_to_back();
    test_jalr_misalign();
    test_illegal();
    test_backpressure();
    test_random(300);
    test_wrap();
    test_reset_mid_flush();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
